// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer that owns the architectural HI/LO registers.
// The result of a mult/div is computed at issue, held in shadow registers, and committed
// to HI/LO after a fixed latency. mthi/mtlo write HI/LO directly with single-cycle latency.
// Ports:
//   clk    - core clock, rising edge
//   reset  - asynchronous active-high reset, clears all state
//   start  - E-stage issue strobe
//   op     - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 ignored
//   a, b   - rs / rt operands
//   d_md   - D-stage instruction is HI/LO-class
//   busy   - unit occupied by a mult/div
//   stall  - D-stage stall request (combinational)
//   hi, lo - architectural HI / LO
module mdu_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCyc = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       hi_n_q, hi_n_d, lo_n_q, lo_n_d;

  logic              md_op;
  logic [31:0]       res_hi, res_lo;
  logic signed [63:0] sa64, sb64, sprod;
  logic [63:0]       uprod;
  logic signed [31:0] sa, sb, squot, srem;

  assign md_op = (op <= 3'd3);

  // Result datapath: evaluated combinationally at issue and parked in the shadow regs.
  always_comb begin
    sa     = $signed(a);
    sb     = $signed(b);
    sa64   = {{32{a[31]}}, a};
    sb64   = {{32{b[31]}}, b};
    sprod  = sa64 * sb64;
    uprod  = {32'd0, a} * {32'd0, b};
    squot  = 32'sd0;
    srem   = 32'sd0;
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (op)
      3'd0: begin
        res_hi = sprod[63:32];
        res_lo = sprod[31:0];
      end
      3'd1: begin
        res_hi = uprod[63:32];
        res_lo = uprod[31:0];
      end
      3'd2: begin
        if (b == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // Quotient overflows; wrap like two's-complement hardware does.
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          squot  = sa / sb;
          srem   = sa % sb;
          res_lo = squot;
          res_hi = srem;
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = a;
        end else begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (md_op) begin
            hi_n_d  = res_hi;
            lo_n_d  = res_lo;
            cnt_d   = op[1] ? CntW'(DIV_CYC - 1) : CntW'(MULT_CYC - 1);
            state_d = StRun;
          end else if (op == 3'd4) begin
            hi_d = a;
          end else if (op == 3'd5) begin
            lo_d = a;
          end
        end
      end
      StRun: begin
        // Issues while running are dropped; the hazard unit should never send any.
        if (cnt_q == '0) begin
          hi_d    = hi_n_q;
          lo_d    = lo_n_q;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign stall = d_md & (busy | (start & md_op));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed plus randomized bench for mdu_ctrl against a behavioural model
// that tracks remaining busy cycles and pending results as plain integers.
module tb_mdu_ctrl;

  localparam int MultCyc = 5;
  localparam int DivCyc  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        d_md;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;

  mdu_ctrl #(
    .MULT_CYC(MultCyc),
    .DIV_CYC (DivCyc)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .d_md (d_md),
    .busy (busy),
    .stall(stall),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural result of a mult/div, straight from the ISA definition.
  task automatic ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] rh, output logic [31:0] rl);
    longint          sp, sq, sr;
    longint unsigned up;
    logic [63:0]     v;
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        v  = sp;
        rh = v[63:32];
        rl = v[31:0];
      end
      3'd1: begin
        up = longint'(x) * longint'(y);
        v  = up;
        rh = v[63:32];
        rl = v[31:0];
      end
      3'd2: begin
        if (y == 0) begin
          rl = 32'hFFFF_FFFF; rh = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 32'd0;
        end else begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) - sq * longint'($signed(y));
          v  = sq; rl = v[31:0];
          v  = sr; rh = v[31:0];
        end
      end
      3'd3: begin
        if (y == 0) begin
          rl = 32'hFFFF_FFFF; rh = x;
        end else begin
          rl = x / y; rh = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: compare comb/registered outputs mid-cycle, advance model, cross the edge.
  task automatic step();
    logic exp_stall;
    @(negedge clk);
    exp_stall = d_md & ((m_left > 0) | (start & (op <= 3'd3)));
    check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    check("stall", {31'd0, stall}, {31'd0, exp_stall});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      if (op <= 3'd3) begin
        ref_result(op, a, b, p_hi, p_lo);
        m_left = op[1] ? DivCyc : MultCyc;
      end else if (op == 3'd4) begin
        m_hi = a;
      end else if (op == 3'd5) begin
        m_lo = a;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset asserted away from any edge; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 0; b = 0; d_md = 1'b0;
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0;
    #1;
    check("init_busy", {31'd0, busy}, 32'd0);
    check("init_hi", hi, 32'd0);
    check("init_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Signed multiply, 5-cycle latency.
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    idle(MultCyc);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // Unsigned multiply; model checks HI/LO hold old values during busy.
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    idle(MultCyc);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // Signed divide and divide-by-zero.
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    idle(DivCyc);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd0);
    idle(DivCyc);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'd7);

    // Signed overflow corner.
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DivCyc);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // mthi / mtlo: single-cycle, never busy.
    issue(3'd4, 32'd1234, 32'd0);
    check("mthi", hi, 32'd1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'd5678, 32'd0);
    check("mtlo", lo, 32'd5678);

    // Issue while running is dropped.
    issue(3'd2, 32'd100, 32'd7);
    idle(2);
    issue(3'd2, 32'd9, 32'd2);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    idle(DivCyc);
    check("ign_lo", lo, 32'd14);
    check("ign_hi", hi, 32'd2);

    // Stall with and without a HI/LO-class instruction in D.
    d_md = 1'b1;
    issue(3'd0, 32'd3, 32'd4);
    idle(MultCyc + 2);
    d_md = 1'b0;
    issue(3'd0, 32'd5, 32'd6);
    idle(MultCyc + 1);

    // Back-to-back: second issue in the cycle busy is still high is dropped.
    d_md = 1'b1;
    issue(3'd0, 32'd2, 32'd3);
    idle(MultCyc - 1);
    issue(3'd0, 32'd10, 32'd10);
    issue(3'd0, 32'd11, 32'd11);
    idle(MultCyc + 1);
    check("b2b_lo", lo, 32'd121);
    d_md = 1'b0;

    // Reset in the middle of a divide; nothing may land afterwards.
    issue(3'd3, 32'd1000, 32'd3);
    idle(2);
    async_reset();
    idle(DivCyc + 2);
    check("post_rst_hi", hi, 32'd0);

    // Randomized traffic against the model.
    for (int it = 0; it < 600; it++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
      d_md  = 1'($urandom);
      step();
      if (it % 149 == 75) async_reset();
    end
    start = 1'b0;
    idle(DivCyc + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
